// File: rtl/pic_rw_control_pkg.sv
// Shared types and bit positions for the 8259A read/write control slice.
package pic_rw_control_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_ICW2,
    ST_WAIT_ICW3,
    ST_WAIT_ICW4,
    ST_READY
  } pic_state_e;

  // Classification of a committed write before state is taken into account.
  typedef enum logic [1:0] {
    WK_ICW1,
    WK_OCW2,
    WK_OCW3,
    WK_A0
  } wr_kind_e;

  // Read source codes handed back to the data bus buffer.
  localparam logic [1:0] RS_IRR = 2'b00;
  localparam logic [1:0] RS_ISR = 2'b01;
  localparam logic [1:0] RS_IMR = 2'b10;

  // ICW1 fields
  localparam int ICW1_FLAG = 4;
  localparam int ICW1_LTIM = 3;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_IC4  = 0;

  // ICW4 fields
  localparam int ICW4_SFNM = 4;
  localparam int ICW4_AEOI = 1;
  localparam int ICW4_UPM  = 0;

  // OCW3 fields
  localparam int OCW3_ESMM = 6;
  localparam int OCW3_SMM  = 5;
  localparam int OCW3_FLAG = 3;
  localparam int OCW3_POLL = 2;
  localparam int OCW3_RR   = 1;
  localparam int OCW3_RIS  = 0;

  // a0=1 words depend on the sequencer state; a0=0 words are told apart by D4/D3.
  function automatic wr_kind_e decode_write(input logic a0, input logic [7:0] d);
    if (a0)                  return WK_A0;
    else if (d[ICW1_FLAG])   return WK_ICW1;
    else if (d[OCW3_FLAG])   return WK_OCW3;
    else                     return WK_OCW2;
  endfunction

endpackage

// File: rtl/pic_rw_control_if.sv
// CPU-side bus of the read/write control block: strobes, address, write data,
// plus the read-source select and drive enable returned to the bus buffer.
interface pic_rw_control_if;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       a0;
  logic [7:0] data_in;
  logic [1:0] read_sel;
  logic       drive_en;

  modport master (
    output cs_n, rd_n, wr_n, a0, data_in,
    input  read_sel, drive_en
  );

  modport slave (
    input  cs_n, rd_n, wr_n, a0, data_in,
    output read_sel, drive_en
  );
endinterface

// File: rtl/pic_rw_control_strobe_edge.sv
// Strobe qualification: detects the trailing edge of a write and registers
// the read-active condition into the bus drive enable.
module pic_strobe_edge (
  input  logic clk,
  input  logic reset,
  input  logic cs_n,
  input  logic rd_n,
  input  logic wr_n,
  output logic wr_act,
  output logic rd_act,
  output logic commit,
  output logic drive_en
);
  logic wr_act_p0;
  logic wr_block;

  assign wr_act = ~cs_n & ~wr_n;
  assign rd_act = ~cs_n & ~rd_n & ~wr_act;
  assign commit = wr_act_p0 & ~wr_act;

  // A write in flight across reset stays blocked until the strobe goes inactive.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_act_p0 <= 1'b0;
      wr_block  <= wr_act;
      drive_en  <= 1'b0;
    end else begin
      wr_act_p0 <= wr_act & ~wr_block;
      if (!wr_act) wr_block <= 1'b0;
      drive_en  <= rd_act;
    end
  end
endmodule

// File: rtl/pic_rw_control.sv
// 8259A read/write control: ICW sequencing, OCW decode, config/mask registers,
// command pulses and read-source selection.
module pic_rw_control
  import pic_rw_control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  pic_rw_control_if.slave bus,
  output logic       init_done,
  output logic [4:0] vector_base,
  output logic       ltim,
  output logic       sngl,
  output logic [7:0] cascade_cfg,
  output logic       aeoi,
  output logic       sfnm,
  output logic       upm,
  output logic [7:0] imr,
  output logic       icw1_pulse,
  output logic       ocw2_pulse,
  output logic [2:0] ocw2_cmd,
  output logic [2:0] ocw2_level,
  output logic       smm,
  output logic       poll_pulse
);
  pic_state_e state;
  wr_kind_e   kind;
  logic       wr_act, rd_act, commit, drive_en_q;
  logic       ic4;
  logic       a0_p0;
  logic [7:0] data_p0;
  logic [1:0] rr_sel, rr_next, read_sel_q;

  pic_strobe_edge u_strobe (
    .clk(clk), .reset(reset), .cs_n(bus.cs_n), .rd_n(bus.rd_n), .wr_n(bus.wr_n),
    .wr_act(wr_act), .rd_act(rd_act), .commit(commit), .drive_en(drive_en_q)
  );

  assign bus.drive_en = drive_en_q;
  assign bus.read_sel = read_sel_q;
  assign kind = decode_write(a0_p0, data_p0);

  // Capture address and data throughout the write; the last captured word commits.
  always_ff @(posedge clk) begin
    if (wr_act) begin
      a0_p0   <= bus.a0;
      data_p0 <= bus.data_in;
    end
  end

  // Register-read choice as it stands after this cycle's commit.
  always_comb begin
    rr_next = rr_sel;
    if (commit) begin
      if (kind == WK_ICW1)
        rr_next = RS_IRR;
      else if (kind == WK_OCW3 && state == ST_READY && data_p0[OCW3_RR])
        rr_next = {1'b0, data_p0[OCW3_RIS]};
    end
  end

  // Read source: an a0=1 read always returns IMR, otherwise the OCW3 choice.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_sel     <= RS_IRR;
      read_sel_q <= RS_IRR;
    end else begin
      rr_sel     <= rr_next;
      read_sel_q <= (rd_act && bus.a0) ? RS_IMR : rr_next;
    end
  end

  // Initialisation sequencer and command decode, all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      ic4         <= 1'b0;
      init_done   <= 1'b0;
      vector_base <= '0;
      ltim        <= 1'b0;
      sngl        <= 1'b0;
      cascade_cfg <= '0;
      aeoi        <= 1'b0;
      sfnm        <= 1'b0;
      upm         <= 1'b0;
      imr         <= '0;
      icw1_pulse  <= 1'b0;
      ocw2_pulse  <= 1'b0;
      ocw2_cmd    <= '0;
      ocw2_level  <= '0;
      smm         <= 1'b0;
      poll_pulse  <= 1'b0;
    end else begin
      icw1_pulse <= 1'b0;
      ocw2_pulse <= 1'b0;
      poll_pulse <= 1'b0;
      if (commit) begin
        unique case (kind)
          WK_ICW1: begin
            state      <= ST_WAIT_ICW2;
            ltim       <= data_p0[ICW1_LTIM];
            sngl       <= data_p0[ICW1_SNGL];
            ic4        <= data_p0[ICW1_IC4];
            imr        <= '0;
            smm        <= 1'b0;
            aeoi       <= 1'b0;
            sfnm       <= 1'b0;
            upm        <= 1'b0;
            init_done  <= 1'b0;
            icw1_pulse <= 1'b1;
          end
          WK_OCW2: begin
            if (state == ST_READY) begin
              ocw2_cmd   <= data_p0[7:5];
              ocw2_level <= data_p0[2:0];
              ocw2_pulse <= 1'b1;
            end
          end
          WK_OCW3: begin
            if (state == ST_READY) begin
              if (data_p0[OCW3_ESMM]) smm <= data_p0[OCW3_SMM];
              if (data_p0[OCW3_POLL]) poll_pulse <= 1'b1;
            end
          end
          WK_A0: begin
            case (state)
              ST_WAIT_ICW2: begin
                vector_base <= data_p0[7:3];
                if (!sngl) state <= ST_WAIT_ICW3;
                else if (ic4) state <= ST_WAIT_ICW4;
                else begin
                  state     <= ST_READY;
                  init_done <= 1'b1;
                end
              end
              ST_WAIT_ICW3: begin
                cascade_cfg <= data_p0;
                if (ic4) state <= ST_WAIT_ICW4;
                else begin
                  state     <= ST_READY;
                  init_done <= 1'b1;
                end
              end
              ST_WAIT_ICW4: begin
                upm       <= data_p0[ICW4_UPM];
                aeoi      <= data_p0[ICW4_AEOI];
                sfnm      <= data_p0[ICW4_SFNM];
                state     <= ST_READY;
                init_done <= 1'b1;
              end
              ST_READY: imr <= data_p0;
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pic_rw_control.sv
// Directed bench for pic_rw_control with a transaction-level reference model
// compared against the DUT every cycle, plus literal spot values.
module tb_pic_rw_control;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pic_rw_control_if bus_if();

  logic       init_done, ltim, sngl, aeoi, sfnm, upm, smm;
  logic       icw1_pulse, ocw2_pulse, poll_pulse;
  logic [4:0] vector_base;
  logic [7:0] cascade_cfg, imr;
  logic [2:0] ocw2_cmd, ocw2_level;

  pic_rw_control dut (
    .clk(clk), .reset(reset), .bus(bus_if),
    .init_done(init_done), .vector_base(vector_base), .ltim(ltim), .sngl(sngl),
    .cascade_cfg(cascade_cfg), .aeoi(aeoi), .sfnm(sfnm), .upm(upm), .imr(imr),
    .icw1_pulse(icw1_pulse), .ocw2_pulse(ocw2_pulse), .ocw2_cmd(ocw2_cmd),
    .ocw2_level(ocw2_level), .smm(smm), .poll_pulse(poll_pulse)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: configured flag plus a queue of ICWs still owed.
  bit         m_cfg;
  int         m_pend[$];
  logic [7:0] e_imr, e_casc;
  logic [4:0] e_vb;
  logic       e_ltim, e_sngl, e_aeoi, e_sfnm, e_upm, e_smm;
  logic [2:0] e_cmd, e_lvl;
  logic [1:0] e_rr;
  logic       e_icw1p, e_ocw2p, e_pollp;
  logic       m_rd_q, m_rd_a0;
  bit         cmp_en = 0;

  function automatic bit m_ready();
    return m_cfg && (m_pend.size() == 0);
  endfunction

  task automatic model_reset();
    m_cfg = 0; m_pend.delete();
    e_imr = 0; e_casc = 0; e_vb = 0; e_ltim = 0; e_sngl = 0;
    e_aeoi = 0; e_sfnm = 0; e_upm = 0; e_smm = 0; e_cmd = 0; e_lvl = 0; e_rr = 0;
    e_icw1p = 0; e_ocw2p = 0; e_pollp = 0; m_rd_q = 0; m_rd_a0 = 0;
  endtask

  task automatic model_commit(input logic a0, input logic [7:0] d);
    int k;
    if (!a0 && d[4]) begin
      m_pend.delete();
      m_pend.push_back(2);
      if (!d[1]) m_pend.push_back(3);
      if (d[0]) m_pend.push_back(4);
      m_cfg = 1;
      e_ltim = d[3]; e_sngl = d[1];
      e_imr = 0; e_smm = 0; e_rr = 0; e_aeoi = 0; e_sfnm = 0; e_upm = 0;
      e_icw1p = 1;
    end else if (a0) begin
      if (m_cfg && m_pend.size() > 0) begin
        k = m_pend.pop_front();
        case (k)
          2: e_vb = d[7:3];
          3: e_casc = d;
          default: begin e_upm = d[0]; e_aeoi = d[1]; e_sfnm = d[4]; end
        endcase
      end else if (m_cfg) begin
        e_imr = d;
      end
    end else if (m_ready()) begin
      if (d[3]) begin
        if (d[6]) e_smm = d[5];
        if (d[2]) e_pollp = 1;
        if (d[1]) e_rr = {1'b0, d[0]};
      end else begin
        e_cmd = d[7:5]; e_lvl = d[2:0]; e_ocw2p = 1;
      end
    end
  endtask

  // One clock: pulses last one cycle; the read seen at the edge drives the bus after it.
  task automatic tick();
    logic rd_now, a0_now, rst_now;
    rd_now  = ~bus_if.cs_n & ~bus_if.rd_n & ~(~bus_if.cs_n & ~bus_if.wr_n);
    a0_now  = bus_if.a0;
    rst_now = reset;
    @(posedge clk); #1;
    e_icw1p = 0; e_ocw2p = 0; e_pollp = 0;
    m_rd_q = rd_now; m_rd_a0 = a0_now;
    if (rst_now) begin model_reset(); cmp_en = 1; end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("init_done", init_done, m_ready());
      chk("vector_base", vector_base, e_vb);
      chk("ltim", ltim, e_ltim);
      chk("sngl", sngl, e_sngl);
      chk("cascade_cfg", cascade_cfg, e_casc);
      chk("aeoi", aeoi, e_aeoi);
      chk("sfnm", sfnm, e_sfnm);
      chk("upm", upm, e_upm);
      chk("imr", imr, e_imr);
      chk("icw1_pulse", icw1_pulse, e_icw1p);
      chk("ocw2_pulse", ocw2_pulse, e_ocw2p);
      chk("ocw2_cmd", ocw2_cmd, e_cmd);
      chk("ocw2_level", ocw2_level, e_lvl);
      chk("smm", smm, e_smm);
      chk("poll_pulse", poll_pulse, e_pollp);
      chk("drive_en", bus_if.drive_en, m_rd_q);
      chk("read_sel", bus_if.read_sel, (m_rd_q && m_rd_a0) ? 2'b10 : e_rr);
    end
  end

  int cnt_icw1 = 0, cnt_ocw2 = 0, cnt_poll = 0;
  always @(negedge clk) begin
    if (icw1_pulse === 1'b1) cnt_icw1++;
    if (ocw2_pulse === 1'b1) cnt_ocw2++;
    if (poll_pulse === 1'b1) cnt_poll++;
  end

  task automatic do_write(input logic a0, input logic [7:0] d,
                          input bit both = 0, input bit cs_first = 0);
    bus_if.a0 = a0; bus_if.data_in = d; bus_if.cs_n = 0; bus_if.wr_n = 0;
    if (both) bus_if.rd_n = 0;
    tick(); tick();
    if (cs_first) begin
      bus_if.cs_n = 1;
      tick(); model_commit(a0, d);
      bus_if.wr_n = 1; bus_if.rd_n = 1;
    end else begin
      bus_if.wr_n = 1; bus_if.cs_n = 1; bus_if.rd_n = 1;
      tick(); model_commit(a0, d);
    end
    tick();
  endtask

  task automatic read_start(input logic a0);
    bus_if.a0 = a0; bus_if.cs_n = 0; bus_if.rd_n = 0;
  endtask

  task automatic read_end();
    bus_if.rd_n = 1; bus_if.cs_n = 1;
    tick(); tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, c2;
    bus_if.cs_n = 1; bus_if.rd_n = 1; bus_if.wr_n = 1; bus_if.a0 = 0; bus_if.data_in = 0;
    reset = 1;
    model_reset();
    tick(); tick();
    reset = 0;
    tick(); tick();
    chk("lit_reset_init_done", init_done, 0);
    chk("lit_reset_read_sel", bus_if.read_sel, 2'b00);
    chk("lit_reset_imr", imr, 8'h00);

    // Single, edge-triggered, with ICW4
    c0 = cnt_icw1;
    do_write(0, 8'h13);
    chk("lit_icw1_pulse_count", cnt_icw1 - c0, 1);
    chk("lit_not_done_after_icw1", init_done, 0);
    do_write(1, 8'h48);
    chk("lit_not_done_after_icw2", init_done, 0);
    do_write(1, 8'h01);
    chk("lit_seq1_init_done", init_done, 1);
    chk("lit_seq1_vector_base", vector_base, 5'h09);
    chk("lit_seq1_upm", upm, 1);
    chk("lit_seq1_sngl", sngl, 1);

    // Mask register and IMR read
    do_write(1, 8'hA5);
    chk("lit_imr_a5", imr, 8'hA5);
    read_start(1);
    chk("lit_drive_en_before_edge", bus_if.drive_en, 0);
    tick();
    chk("lit_drive_en_read", bus_if.drive_en, 1);
    chk("lit_read_sel_imr", bus_if.read_sel, 2'b10);
    tick();
    read_end();
    chk("lit_read_sel_restored", bus_if.read_sel, 2'b00);

    // OCW2, OCW3 register select, special mask + poll
    c1 = cnt_ocw2;
    do_write(0, 8'h63);
    chk("lit_ocw2_pulse_count", cnt_ocw2 - c1, 1);
    chk("lit_ocw2_cmd", ocw2_cmd, 3'b011);
    chk("lit_ocw2_level", ocw2_level, 3'b011);
    do_write(0, 8'h0B);
    chk("lit_ocw3_read_isr", bus_if.read_sel, 2'b01);
    c2 = cnt_poll;
    do_write(0, 8'h6C);
    chk("lit_smm_set", smm, 1);
    chk("lit_poll_pulse_count", cnt_poll - c2, 1);
    chk("lit_rr_kept", bus_if.read_sel, 2'b01);
    read_start(0); tick(); tick(); read_end();
    read_start(1); tick(); tick(); read_end();
    chk("lit_rr_after_imr_read", bus_if.read_sel, 2'b01);

    // Write wins over a simultaneous read; cs_n rise commits
    do_write(1, 8'h3C, 1, 0);
    chk("lit_imr_write_wins", imr, 8'h3C);
    do_write(1, 8'h5A, 0, 1);
    chk("lit_imr_cs_commit", imr, 8'h5A);

    // Cascaded, with ICW3 and ICW4
    do_write(0, 8'h11);
    chk("lit_seq2_imr_cleared", imr, 8'h00);
    chk("lit_seq2_smm_cleared", smm, 0);
    chk("lit_seq2_read_sel_cleared", bus_if.read_sel, 2'b00);
    do_write(1, 8'h20);
    chk("lit_seq2_vb", vector_base, 5'h04);
    chk("lit_seq2_wait_icw3", init_done, 0);
    do_write(1, 8'h04);
    chk("lit_seq2_casc", cascade_cfg, 8'h04);
    chk("lit_seq2_wait_icw4", init_done, 0);
    do_write(1, 8'h03);
    chk("lit_seq2_aeoi", aeoi, 1);
    chk("lit_seq2_done", init_done, 1);

    // Restart mid-sequence; OCW2 ignored while initialising
    do_write(1, 8'hFF);
    c0 = cnt_icw1;
    do_write(0, 8'h13);
    chk("lit_restart_imr", imr, 8'h00);
    do_write(1, 8'h48);
    do_write(0, 8'h12);
    chk("lit_restart_pulses", cnt_icw1 - c0, 2);
    c1 = cnt_ocw2;
    do_write(0, 8'h20);
    chk("lit_ocw2_ignored", cnt_ocw2 - c1, 0);
    do_write(1, 8'h50);
    chk("lit_restart_done", init_done, 1);
    chk("lit_restart_vb", vector_base, 5'h0A);

    // Reset in the middle of a write: no commit afterwards
    c0 = cnt_icw1;
    bus_if.a0 = 0; bus_if.data_in = 8'h13; bus_if.cs_n = 0; bus_if.wr_n = 0;
    tick(); tick();
    reset = 1;
    tick(); tick();
    reset = 0;
    tick(); tick();
    bus_if.wr_n = 1; bus_if.cs_n = 1;
    tick(); tick();
    chk("lit_rst_wr_no_pulse", cnt_icw1 - c0, 0);
    chk("lit_rst_wr_init_done", init_done, 0);
    chk("lit_rst_wr_imr", imr, 8'h00);
    do_write(1, 8'h48);
    chk("lit_idle_a0_ignored", vector_base, 5'h00);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
